audio_data_gen: RTL and testbench
=================================

Name: audio_data_gen

Overview:
Parametrised multi-channel audio sample generator that feeds the S/PDIF / SDIO audio datapath and its testbenches. Each frame period it emits one sample word for each of CH_NUM channels on a valid/ready stream, tagged with the channel number. It supports four pattern modes and flags dropped frames when the downstream stalls too long.

Parameters:
DATA_W, 32, sample word width (1..32)
CH_NUM, 2, channels per frame (1..16)
CH_W, 4, channel-number width; must satisfy 2^CH_W >= CH_NUM
RATE_DIV, 256, iclk cycles per frame period; must be >= CH_NUM+1
LFSR_SEED, 32'h0000_0001, LFSR reset value; must be non-zero

Ports:
iclk  in  1  system clock
irst  in  1  reset, synchronous, active-low
ien  in  1  generator enable
imode  in  2  pattern: 0 ramp, 1 constant, 2 LFSR, 3 channel-id
iconst  in  DATA_W  constant pattern value
iready  in  1  downstream accepts the current word
och_data  out  DATA_W  sample word
och_num  out  CH_W  channel number of och_data
och_data_valid  out  1  word valid
oframe_start  out  1  one-cycle pulse with channel 0's first valid cycle
ooverrun  out  1  sticky: a frame tick arrived while the previous frame was still being sent
oframe_cnt  out  16  number of completed frames, wraps

Behaviour:
- Reset (irst=0 at a rising edge):
  - all outputs 0, rate counter 0, FSM in IDLE, frame_cnt 0, LFSR = LFSR_SEED.
  - Reset mid-frame abandons the frame immediately.
- Rate counter:
  - counts 0..RATE_DIV-1 while ien=1 and wraps.
  - Held at 0 while ien=0.
  - Tick = count==RATE_DIV-1 with ien=1.
- FSM states: IDLE, SEND.
  - IDLE + tick: latch imode and iconst, set ch=0, go to SEND. The next cycle has och_data_valid=1, och_num=0 and oframe_start=1 (1-cycle latency from the tick).
  - SEND: a word transfers when och_data_valid & iready.
    - On transfer with ch<CH_NUM-1: ch+1 next cycle, and valid stays high.
    - On transfer with ch==CH_NUM-1: valid=0 next cycle, frame_cnt+1, go to IDLE.
    - While iready=0: och_data, och_num and valid are held stable. Valid never drops without a transfer.
  - With iready held at 1, a frame occupies exactly CH_NUM consecutive valid cycles.
- Overrun:
  - A tick while in SEND sets ooverrun=1 and that frame is dropped (no queueing).
  - ooverrun is cleared only by reset.
  - A tick in the same cycle as the last transfer counts as overrun and is dropped.
- ien deasserted mid-frame: the current frame completes, and no new ticks occur.
- Patterns are computed from the latched mode. Arithmetic is modulo 2^DATA_W.
  - ramp: data = frame_cnt (zero-extended or truncated to DATA_W) + ch.
  - constant: data = latched iconst.
  - LFSR:
    - 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003).
    - data = lfsr[DATA_W-1:0].
    - The LFSR advances once per transferred word and only in LFSR mode.
  - channel-id: data[CH_W-1:0] = ch; the upper bits hold frame_cnt truncated to DATA_W-CH_W bits, or are 0 when DATA_W <= CH_W.
- mode/iconst changes mid-frame have no effect until the next frame start.
- och_num always equals the current channel index; it is 0 when idle.

Test Plan:
1. Ramp, default params, iready=1, ien=1 for 3 frames:
   - oframe_start pulses 257 cycles after reset release, then every 256 cycles.
   - Words are (0,ch0),(1,ch1), then (1,ch0),(2,ch1), then (2,ch0),(3,ch1).
   - oframe_cnt ends at 3.
2. Backpressure: CH_NUM=4, iready low for 10 cycles mid-frame:
   - och_data and och_num are held stable and valid stays 1.
   - After release the remaining channels follow with no gaps.
   - ooverrun stays 0.
3. Overrun: RATE_DIV=8, CH_NUM=4, iready=0 for 20 cycles:
   - ooverrun=1 and stays 1.
   - The dropped frame does not increment oframe_cnt.
   - The next frame starts at ch0.
4. LFSR, DATA_W=16, seed 1, iready=1:
   - Successive words match a reference Galois LFSR (mask 8020_0003) truncated to 16 bits.
   - Constant mode with iconst=16'hA5A5 yields A5A5 on every channel.
5. Mode change and ien drop mid-frame:
   - The frame completes in the latched mode.
   - No further oframe_start occurs while ien=0.
   - Re-enable gives the first tick RATE_DIV cycles later.
6. Reset mid-frame:
   - valid, ooverrun and oframe_cnt clear in the next cycle.
   - The LFSR restarts at LFSR_SEED, and the first post-reset word matches case 4's first word.

Source files
------------

// File: rtl/audio_data_gen.sv
// Multi-channel audio sample generator: one word per channel each frame period,
// streamed on valid/ready with ramp, constant, LFSR and channel-id patterns.
module audio_data_gen #(
    parameter int          DATA_W    = 32,
    parameter int          CH_NUM    = 2,
    parameter int          CH_W      = 4,
    parameter int          RATE_DIV  = 256,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              ien,
    input  logic [1:0]        imode,
    input  logic [DATA_W-1:0] iconst,
    input  logic              iready,
    output logic [DATA_W-1:0] och_data,
    output logic [CH_W-1:0]   och_num,
    output logic              och_data_valid,
    output logic              oframe_start,
    output logic              ooverrun,
    output logic [15:0]       oframe_cnt
);

    localparam int               CNT_W   = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATE_DIV - 1);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(CH_NUM - 1);
    localparam logic [31:0]      LFSR_MASK = 32'h8020_0003;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [1:0] MODE_RAMP  = 2'd0;
    localparam logic [1:0] MODE_CONST = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_CHID  = 2'd3;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [0:0]        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] const_q, const_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic              start_q, start_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic              tick;
    logic [DATA_W-1:0] data_sel;

    // Frame-period divider; parked at zero while disabled so re-enable waits a full period.
    always_comb begin
        tick  = ien && (cnt_q == CNT_MAX);
        cnt_d = cnt_q;
        if (!ien || cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        mode_d      = mode_q;
        const_d     = const_q;
        lfsr_d      = lfsr_q;
        start_d     = 1'b0;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;

        if (state_q == ST_IDLE) begin
            if (tick) begin
                mode_d  = imode;
                const_d = iconst;
                ch_d    = '0;
                start_d = 1'b1;
                state_d = ST_SEND;
            end
        end else begin
            // A tick while busy (including on the final transfer) drops that frame.
            if (tick) begin
                overrun_d = 1'b1;
            end
            if (iready) begin
                if (mode_q == MODE_LFSR) begin
                    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
                end
                if (ch_q == CH_LAST) begin
                    ch_d        = '0;
                    state_d     = ST_IDLE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
        end
    end

    // Pattern words come from registered state only, so they hold while stalled.
    always_comb begin
        data_sel = '0;
        case (mode_q)
            MODE_RAMP:  data_sel = DATA_W'(frame_cnt_q) + DATA_W'(ch_q);
            MODE_CONST: data_sel = const_q;
            MODE_LFSR:  data_sel = lfsr_q[DATA_W-1:0];
            MODE_CHID:  data_sel = DATA_W'({frame_cnt_q, ch_q});
            default:    data_sel = '0;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!irst) begin
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            mode_q      <= MODE_RAMP;
            const_q     <= '0;
            lfsr_q      <= LFSR_SEED;
            start_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            ch_q        <= ch_d;
            mode_q      <= mode_d;
            const_q     <= const_d;
            lfsr_q      <= lfsr_d;
            start_q     <= start_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign och_data_valid = (state_q == ST_SEND);
    assign och_data       = (state_q == ST_SEND) ? data_sel : '0;
    assign och_num        = ch_q;
    assign oframe_start   = start_q;
    assign ooverrun       = overrun_q;
    assign oframe_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_audio_data_gen.sv
// Bench for audio_data_gen: directed phases with randomized ready/const inputs,
// checked every cycle against a frame-level reference model.
module tb_audio_data_gen;

   localparam int          DATA_W   = 16;
   localparam int          CH_NUM   = 4;
   localparam int          CH_W     = 4;
   localparam int          RATE_DIV = 16;
   localparam logic [31:0] SEED     = 32'h0000_0001;

   logic              iclk = 1'b0;
   logic              irst;
   logic              ien;
   logic [1:0]        imode;
   logic [DATA_W-1:0] iconst;
   logic              iready;
   logic [DATA_W-1:0] och_data;
   logic [CH_W-1:0]   och_num;
   logic              och_data_valid;
   logic              oframe_start;
   logic              ooverrun;
   logic [15:0]       oframe_cnt;

   int checks = 0;
   int failures = 0;

   // Reference model: a frame is a queue of pre-computed (word, channel) pairs
   int                mCnt;
   bit                mBusy;
   bit                mStart;
   bit                mOverrun;
   logic [15:0]       mFrameCnt;
   logic [31:0]       mLfsr;
   logic [1:0]        mMode;
   logic [DATA_W-1:0] mData[$];
   int                mCh[$];

   always #5 iclk = ~iclk;

   audio_data_gen #(
      .DATA_W(DATA_W), .CH_NUM(CH_NUM), .CH_W(CH_W),
      .RATE_DIV(RATE_DIV), .LFSR_SEED(SEED)
   ) dut (
      .iclk(iclk), .irst(irst), .ien(ien), .imode(imode), .iconst(iconst),
      .iready(iready), .och_data(och_data), .och_num(och_num),
      .och_data_valid(och_data_valid), .oframe_start(oframe_start),
      .ooverrun(ooverrun), .oframe_cnt(oframe_cnt)
   );

   function automatic logic [31:0] nextLfsr(input logic [31:0] l);
      return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   // Build the whole frame's words from the pattern rules at the moment it starts
   task automatic startFrame();
      logic [31:0] tmp;
      logic [DATA_W-1:0] d;
      tmp = mLfsr;
      mMode = imode;
      for (int k = 0; k < CH_NUM; k++) begin
         case (imode)
            2'd0:    d = DATA_W'(int'(mFrameCnt) + k);
            2'd1:    d = iconst;
            2'd2:    begin d = tmp[DATA_W-1:0]; tmp = nextLfsr(tmp); end
            default: d = DATA_W'((int'(mFrameCnt) << CH_W) + k);
         endcase
         mData.push_back(d);
         mCh.push_back(k);
      end
      mBusy = 1'b1;
      mStart = 1'b1;
   endtask

   task automatic modelEdge();
      bit tick;
      if (!irst) begin
         mCnt = 0; mBusy = 0; mStart = 0; mOverrun = 0;
         mFrameCnt = 16'd0; mLfsr = SEED; mMode = 2'd0;
         mData.delete(); mCh.delete();
      end else begin
         tick = ien && (mCnt == RATE_DIV - 1);
         mCnt = ien ? (mCnt + 1) % RATE_DIV : 0;
         mStart = 1'b0;
         if (mBusy) begin
            if (tick) mOverrun = 1'b1;
            if (iready) begin
               void'(mData.pop_front());
               void'(mCh.pop_front());
               if (mMode == 2'd2) mLfsr = nextLfsr(mLfsr);
               if (mData.size() == 0) begin
                  mBusy = 1'b0;
                  mFrameCnt = mFrameCnt + 16'd1;
               end
            end
         end else if (tick) begin
            startFrame();
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [CH_W-1:0] expNum;
      expNum = mBusy ? CH_W'(mCh[0]) : '0;
      checks++;
      assert (och_data_valid === mBusy) else begin
         failures++;
         $error("[TB] FAIL %s valid observed=%0b expected=%0b", tag, och_data_valid, mBusy);
      end
      checks++;
      assert (och_num === expNum) else begin
         failures++;
         $error("[TB] FAIL %s och_num observed=%0d expected=%0d", tag, och_num, expNum);
      end
      checks++;
      assert (oframe_start === mStart) else begin
         failures++;
         $error("[TB] FAIL %s frame_start observed=%0b expected=%0b", tag, oframe_start, mStart);
      end
      checks++;
      assert (ooverrun === mOverrun) else begin
         failures++;
         $error("[TB] FAIL %s overrun observed=%0b expected=%0b", tag, ooverrun, mOverrun);
      end
      checks++;
      assert (oframe_cnt === mFrameCnt) else begin
         failures++;
         $error("[TB] FAIL %s frame_cnt observed=%0d expected=%0d", tag, oframe_cnt, mFrameCnt);
      end
      if (mBusy) begin
         checks++;
         assert (och_data === mData[0]) else begin
            failures++;
            $error("[TB] FAIL %s data observed=%h expected=%h", tag, och_data, mData[0]);
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model on the edge, check mid-cycle
   task automatic applyStimulus(input logic rstN, input logic en, input logic [1:0] mode,
                                input logic [DATA_W-1:0] cst, input logic rdy, input string tag);
      irst = rstN; ien = en; imode = mode; iconst = cst; iready = rdy;
      @(posedge iclk);
      modelEdge();
      @(negedge iclk);
      checkOutput(tag);
   endtask

   // rdyMode: 0 low, 1 high, 2 random (~75% high)
   task automatic runCycles(input int n, input logic en, input logic [1:0] mode,
                            input logic [DATA_W-1:0] cst, input int rdyMode, input string tag);
      logic rdy;
      for (int i = 0; i < n; i++) begin
         rdy = (rdyMode == 2) ? ($urandom_range(3) != 0) : (rdyMode == 1);
         applyStimulus(1'b1, en, mode, cst, rdy, tag);
      end
   endtask

   // Run with ready high until the model shows the given channel pending, bounded
   task automatic waitForChannel(input int ch, input logic [1:0] mode, input string tag);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 4 * RATE_DIV && !found; i++) begin
         if (mBusy && mCh[0] == ch) found = 1'b1;
         else applyStimulus(1'b1, 1'b1, mode, 16'h0000, 1'b1, tag);
      end
      checks++;
      assert (found) else begin
         failures++;
         $error("[TB] FAIL %s wait_channel observed=timeout expected=ch%0d", tag, ch);
      end
   endtask

   initial begin
      bit seenValid;
      irst = 1'b0; ien = 1'b0; imode = 2'd0; iconst = '0; iready = 1'b0;

      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, "reset");

      $display("[TB] ramp frames");
      runCycles(3 * RATE_DIV + 8, 1'b1, 2'd0, 16'h0000, 1, "ramp");

      $display("[TB] backpressure");
      waitForChannel(1, 2'd0, "bp_wait");
      runCycles(10, 1'b1, 2'd0, 16'h0000, 0, "bp_stall");
      runCycles(RATE_DIV, 1'b1, 2'd0, 16'h0000, 1, "bp_release");

      $display("[TB] overrun");
      waitForChannel(1, 2'd3, "ovr_wait");
      runCycles(20, 1'b1, 2'd3, 16'h0000, 0, "ovr_stall");
      runCycles(3 * RATE_DIV, 1'b1, 2'd3, 16'h0000, 1, "ovr_recover");

      $display("[TB] lfsr and constant");
      runCycles(10 * RATE_DIV, 1'b1, 2'd2, 16'h0000, 2, "lfsr");
      runCycles(3 * RATE_DIV, 1'b1, 2'd1, 16'hA5A5, 1, "const");
      for (int i = 0; i < 4 * RATE_DIV; i++)
         runCycles(1, 1'b1, 2'($urandom_range(3)), 16'($urandom), 2, "mixed");

      $display("[TB] mode change and enable drop mid-frame");
      waitForChannel(1, 2'd0, "ien_wait");
      runCycles(3 * RATE_DIV, 1'b0, 2'd3, 16'h1234, 1, "ien_off");
      runCycles(2 * RATE_DIV + 4, 1'b1, 2'd1, 16'h5A5A, 1, "ien_on");

      $display("[TB] reset mid-frame");
      waitForChannel(2, 2'd2, "rst_wait");
      applyStimulus(1'b0, 1'b1, 2'd2, 16'h0000, 1'b1, "rst_mid");
      seenValid = 1'b0;
      for (int i = 0; i < 2 * RATE_DIV && !seenValid; i++) begin
         applyStimulus(1'b1, 1'b1, 2'd2, 16'h0000, 1'b1, "rst_after");
         if (mBusy) seenValid = 1'b1;
      end
      checks++;
      assert (seenValid && och_data === SEED[DATA_W-1:0]) else begin
         failures++;
         $error("[TB] FAIL rst_first_word observed=%h expected=%h", och_data, SEED[DATA_W-1:0]);
      end
      runCycles(2 * RATE_DIV, 1'b1, 2'd2, 16'h0000, 1, "rst_lfsr");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
